// File: rtl/carry_stage_if.sv
// ----------------------------------------------------------------------------
// carry_stage_if
// Purpose : bundles the upstream (H/G/P/cin + valid/ready) and downstream
//           (sum/cout + valid/ready, stall counter) signals of carry_stage.
// Parameter:
//   STALL_CNT_W - width of the stall counter; must match carry_stage.
// Signals:
//   H3..H0, G3..G0, P3..P0 : per-bit half-sum / generate / propagate
//   cin                    : carry-in
//   in_valid / in_ready    : upstream handshake
//   sum[3:0], cout         : result of the oldest buffered entry
//   out_valid / out_ready  : downstream handshake
//   stall_cnt              : saturating count of output-stalled cycles
// Modports:
//   master - the side that feeds operands and consumes results (bench)
//   slave  - the carry stage itself
// ----------------------------------------------------------------------------
interface carry_stage_if #(
    parameter int unsigned STALL_CNT_W = 8
);
    logic                   H3, H2, H1, H0;
    logic                   G3, G2, G1, G0;
    logic                   P3, P2, P1, P0;
    logic                   cin;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             sum;
    logic                   cout;
    logic                   out_valid;
    logic                   out_ready;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output H3, H2, H1, H0,
        output G3, G2, G1, G0,
        output P3, P2, P1, P0,
        output cin, in_valid, out_ready,
        input  in_ready, sum, cout, out_valid, stall_cnt
    );

    modport slave (
        input  H3, H2, H1, H0,
        input  G3, G2, G1, G0,
        input  P3, P2, P1, P0,
        input  cin, in_valid, out_ready,
        output in_ready, sum, cout, out_valid, stall_cnt
    );
endinterface

// File: rtl/carry_stage.sv
// ----------------------------------------------------------------------------
// carry_stage
// Purpose : final carry stage of a 4-bit adder. Takes per-bit half-sum,
//           generate and propagate terms, ripples the carries, and stores the
//           result in a 2-entry skid buffer with valid/ready on both sides.
// Ports   :
//   clk   - rising-edge clock for all state
//   rst_n - asynchronous active-low reset
//   bus   - carry_stage_if.slave (operands, results, handshakes, stall count)
// Parameter:
//   STALL_CNT_W - width of the saturating output-stall counter
// Build option:
//   CARRY_STAGE_EAC_EN - when defined, the adder runs modulo 15 with an
//   end-around carry: c0 is the group generate, cin is ignored, cout is 0
//   and an all-ones result is folded to zero.
// ----------------------------------------------------------------------------
module carry_stage #(
    parameter int unsigned STALL_CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    carry_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    // Entry layout: {cout, sum[3:0]}
    function automatic logic [4:0] compute_entry(
        input logic [3:0] h,
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c_in
    );
        logic [4:0] c;
        logic [3:0] s;
`ifdef CARRY_STAGE_EAC_EN
        // End-around carry: the group generate re-enters as the carry-in.
        c[0] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
`else
        c[0] = c_in;
`endif
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            s[i]   = h[i] ^ c[i];
        end
`ifdef CARRY_STAGE_EAC_EN
        // 1111 is the second encoding of zero in modulo-15 arithmetic.
        if (s == 4'b1111) begin
            s = 4'b0000;
        end else begin
            s = s;
        end
        return {1'b0, s};
`else
        return {c[4], s};
`endif
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_ent0;      // oldest entry, drives the outputs
    logic [4:0]             r_ent1;      // younger entry, only valid in TWO
    logic [4:0]             w_ent0_nxt;
    logic [4:0]             w_ent1_nxt;
    logic [4:0]             w_new;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [STALL_CNT_W-1:0] w_stall_nxt;
    logic                   w_push;
    logic                   w_pop;
    logic [3:0]             w_h;
    logic [3:0]             w_g;
    logic [3:0]             w_p;

    assign w_h    = {bus.H3, bus.H2, bus.H1, bus.H0};
    assign w_g    = {bus.G3, bus.G2, bus.G1, bus.G0};
    assign w_p    = {bus.P3, bus.P2, bus.P1, bus.P0};
    assign w_new  = compute_entry(w_h, w_g, w_p, bus.cin);
    // Handshakes use the registered ready/valid, so no input reaches an output
    // combinationally.
    assign w_push = bus.in_valid & r_in_ready;
    assign w_pop  = r_out_valid & bus.out_ready;

    // Next-state and buffer-update logic of the skid FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                    w_ent0_nxt  = w_new;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    // Popped entry is replaced in place by the new one.
                    w_state_nxt = ST_ONE;
                    w_ent0_nxt  = w_new;
                end else if (w_push) begin
                    w_state_nxt = ST_TWO;
                    w_ent1_nxt  = w_new;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                    w_ent0_nxt  = 5'b00000;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can occur.
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_ent0_nxt  = r_ent1;
                    w_ent1_nxt  = 5'b00000;
                end else begin
                    w_state_nxt = ST_TWO;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_ent0_nxt  = 5'b00000;
                w_ent1_nxt  = 5'b00000;
            end
        endcase
    end

    // Saturating count of cycles where a result is held back by downstream.
    always_comb begin
        w_stall_nxt = r_stall_cnt;
        if (r_out_valid && !bus.out_ready) begin
            if (r_stall_cnt != STALL_MAX) begin
                w_stall_nxt = r_stall_cnt + STALL_ONE;
            end else begin
                w_stall_nxt = r_stall_cnt;
            end
        end else begin
            w_stall_nxt = r_stall_cnt;
        end
    end

    // State, buffer entries and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_ent0      <= 5'b00000;
            r_ent1      <= 5'b00000;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ent0      <= w_ent0_nxt;
            r_ent1      <= w_ent1_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_stall_cnt <= w_stall_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_ent0[3:0];
    assign bus.cout      = r_ent0[4];
    assign bus.stall_cnt = r_stall_cnt;

endmodule
